// File: rtl/my_isolation_ctrl.sv
// Operand-isolation controller: gates a functional unit's operands off when idle and
// sequences a settle period before granting requests. Optional macro: ISOLATION_STATS_EN.
module my_isolation_ctrl #(
  parameter int unsigned IDLE_TIMEOUT = 4,
  parameter int unsigned WAKE_CYCLES  = 1
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iReq,
  input  logic        iBusy,
  input  logic        iForce_Active,
  output logic        oIsolation_Signal,
  output logic        oGrant,
  output logic [1:0]  oState,
  output logic [15:0] oWake_Count
);

  typedef enum logic [1:0] {
    StIsolated = 2'b00,
    StWake     = 2'b01,
    StActive   = 2'b10
  } state_e;

  localparam logic [7:0] IdleLoad = 8'(IDLE_TIMEOUT);
  localparam logic [3:0] WakeLoad = 4'(WAKE_CYCLES - 1);

  state_e     state_q;
  logic [7:0] idle_cnt_q;
  logic [3:0] wake_cnt_q;
  logic       wake_req;
  logic       activity;

  assign wake_req = iReq | iForce_Active;
  assign activity = iReq | iBusy | iForce_Active;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q    <= StIsolated;
      idle_cnt_q <= 8'd0;
      wake_cnt_q <= 4'd0;
    end else begin
      unique case (state_q)
        StIsolated: begin
          if (wake_req) begin
            state_q    <= StWake;
            wake_cnt_q <= WakeLoad;
          end
        end
        // Wake always completes; a dropped request does not abort it.
        StWake: begin
          if (wake_cnt_q == 4'd0) begin
            state_q    <= StActive;
            idle_cnt_q <= IdleLoad;
          end else begin
            wake_cnt_q <= wake_cnt_q - 4'd1;
          end
        end
        StActive: begin
          if (activity) begin
            idle_cnt_q <= IdleLoad;
          end else if (idle_cnt_q <= 8'd1) begin
            state_q    <= StIsolated;
            idle_cnt_q <= 8'd0;
          end else begin
            idle_cnt_q <= idle_cnt_q - 8'd1;
          end
        end
        default: begin
          state_q    <= StIsolated;
          idle_cnt_q <= 8'd0;
          wake_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them without a clock edge.
  assign oIsolation_Signal = (state_q != StIsolated);
  assign oGrant            = (state_q == StActive) & iReq;
  assign oState            = state_q;

`ifdef ISOLATION_STATS_EN
  logic [15:0] wake_count_q;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wake_count_q <= 16'h0000;
    end else if ((state_q == StIsolated) && wake_req && (wake_count_q != 16'hFFFF)) begin
      wake_count_q <= wake_count_q + 16'h0001;
    end
  end

  assign oWake_Count = wake_count_q;
`else
  assign oWake_Count = 16'h0000;
`endif

endmodule

// File: tb/tb_my_isolation_ctrl.sv
// Scoreboard bench for my_isolation_ctrl: a cycle-level model of the isolate/wake/idle rules
// predicts every output; a monitor pops and compares once per cycle.
module tb_my_isolation_ctrl;

  localparam int unsigned IdleTo = 4;
  localparam int unsigned WakeCy = 3;

  logic        iClk = 1'b0;
  logic        iReset = 1'b1;
  logic        iReq = 1'b0;
  logic        iBusy = 1'b0;
  logic        iForce_Active = 1'b0;
  logic        oIsolation_Signal;
  logic        oGrant;
  logic [1:0]  oState;
  logic [15:0] oWake_Count;

  my_isolation_ctrl #(
    .IDLE_TIMEOUT(IdleTo),
    .WAKE_CYCLES (WakeCy)
  ) dut (
    .iClk             (iClk),
    .iReset           (iReset),
    .iReq             (iReq),
    .iBusy            (iBusy),
    .iForce_Active    (iForce_Active),
    .oIsolation_Signal(oIsolation_Signal),
    .oGrant           (oGrant),
    .oState           (oState),
    .oWake_Count      (oWake_Count)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic        iso;
    logic        grant;
    logic [1:0]  st;
    logic [15:0] wc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: isolated flag, remaining settle cycles, consecutive idle active cycles.
  bit m_iso;
  int m_wake_left;
  int m_idle;
  int m_wakes;

  function automatic void model_reset();
    m_iso       = 1'b1;
    m_wake_left = 0;
    m_idle      = 0;
    m_wakes     = 0;
  endfunction

  function automatic void check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got iso/grant/state/wakes=%h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input logic r, input logic b, input logic f, output logic g);
    exp_t e;
    @(negedge iClk);
    iReq = r;
    iBusy = b;
    iForce_Active = f;
    if (m_iso) begin
      e.iso = 1'b0; e.grant = 1'b0; e.st = 2'b00;
    end else if (m_wake_left > 0) begin
      e.iso = 1'b1; e.grant = 1'b0; e.st = 2'b01;
    end else begin
      e.iso = 1'b1; e.grant = r; e.st = 2'b10;
    end
`ifdef ISOLATION_STATS_EN
    e.wc = 16'(m_wakes);
`else
    e.wc = 16'h0000;
`endif
    sb_q.push_back(e);
    g = e.grant;
    if (m_iso) begin
      if (r || f) begin
        m_iso       = 1'b0;
        m_wake_left = WakeCy;
        if (m_wakes < 65535) m_wakes++;
      end
    end else if (m_wake_left > 0) begin
      m_wake_left--;
      m_idle = 0;
    end else begin
      m_idle = (r || b || f) ? 0 : m_idle + 1;
      if (m_idle == IdleTo) m_iso = 1'b1;
    end
  endtask

  task automatic async_reset();
    @(negedge iClk);
    #4;
    iReq = 1'b0;
    iBusy = 1'b0;
    iForce_Active = 1'b0;
    iReset = 1'b1;
    #1;
    check("async_reset", {oIsolation_Signal, oGrant, oState, oWake_Count}, 20'h0);
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iReset = 1'b0;
    model_reset();
  endtask

  task automatic req_until_grant();
    logic g;
    g = 1'b0;
    for (int i = 0; i < WakeCy + 4 && !g; i++) step(1'b1, 1'b0, 1'b0, g);
    n_cmp++;
    if (!g) begin
      n_bad++;
      $display("FAIL grant_timeout: got no grant expected grant within %0d cycles", WakeCy + 4);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge iClk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("cycle", {oIsolation_Signal, oGrant, oState, oWake_Count}, e);
        if (oGrant && !oIsolation_Signal) check("grant_while_isolated", 20'h1, 20'h0);
      end
    end
  end

  initial begin : driver
    logic g;
    logic hold;
    int   pct;
    model_reset();
    #3;
    check("reset_values", {oIsolation_Signal, oGrant, oState, oWake_Count}, 20'h0);
    repeat (2) @(negedge iClk);
    iReset = 1'b0;

    req_until_grant();
    repeat (IdleTo + 2) step(1'b0, 1'b0, 1'b0, g);

    req_until_grant();
    repeat (10) step(1'b0, 1'b1, 1'b0, g);
    repeat (IdleTo + 2) step(1'b0, 1'b0, 1'b0, g);

    repeat (3) step(1'b0, 1'b1, 1'b0, g);

    step(1'b1, 1'b0, 1'b0, g);
    repeat (WakeCy + IdleTo + 2) step(1'b0, 1'b0, 1'b0, g);

    repeat (5) step(1'b0, 1'b0, 1'b1, g);
    repeat (IdleTo + 2) step(1'b0, 1'b0, 1'b0, g);

    step(1'b1, 1'b0, 1'b0, g);
    async_reset();
    req_until_grant();
    async_reset();
    req_until_grant();
    repeat (IdleTo + 2) step(1'b0, 1'b0, 1'b0, g);

    hold = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      unique case ((i / 100) % 3)
        0: pct = 33;
        1: pct = 5;
        default: pct = 50;
      endcase
      if (i == 700) begin
        async_reset();
        hold = 1'b0;
      end
      if (!hold && $urandom_range(0, 99) < pct) hold = 1'b1;
      step(hold, $urandom_range(0, 9) < ((i / 100) % 3 == 1 ? 1 : 3),
           $urandom_range(0, 29) == 0, g);
      if (g) hold = 1'($urandom_range(0, 1));
    end

    repeat (3) @(negedge iClk);
    check("scoreboard_drain", 20'(sb_q.size()), 20'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
